// File: rtl/current_adc_reader.sv
// current_adc_reader: periodic SPI read of a 12-bit MCP3201-class current ADC.
// A free-running period counter triggers each conversion; the FSM drives
// chip-select and SCLK, shifts MISO in MSB first and publishes the word with
// a one-cycle valid strobe.
//
// state | meaning
// IDLE  | cs_n high, sclk low, waiting for period count 0
// SETUP | cs_n low for CLK_DIV cycles before the first SCLK rise
// SHIFT | LEAD_BITS+12 SCLK periods, MISO captured at the end of each high phase
// DONE  | one cycle, cs_n high, sample published with valid strobe
module current_adc_reader #(
    parameter int CLK_DIV       = 25,
    parameter int LEAD_BITS     = 3,
    parameter int SAMPLE_PERIOD = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adc_miso,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [11:0] current_b_out,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int NBITS  = LEAD_BITS + 12;
    localparam int NHALF  = 2 * NBITS;
    localparam int PER_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TMR_W  = $clog2(CLK_DIV);
    localparam int HALF_W = $clog2(NHALF);

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(NHALF - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [PER_W-1:0]   per_cnt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [HALF_W-1:0]  half, half_nxt;
    logic [11:0]        shreg, shreg_nxt;
    logic               miso_meta, miso_sync;
    logic               period_zero;
    logic               cs_n_nxt, sclk_nxt;

    assign period_zero = (per_cnt == '0);
    assign busy        = (state != IDLE);

    // Two-flop synchronizer for the asynchronous ADC data line.
    always_ff @(posedge clk) begin
        miso_meta <= adc_miso;
        miso_sync <= miso_meta;
    end

    // Free-running conversion-rate counter, 0..SAMPLE_PERIOD-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt <= '0;
        end else if (per_cnt == PER_LAST) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // Next-state, half-period timer and capture logic.
    // Even half indices are SCLK high phases; the last cycle of each high
    // phase is the capture point, one cycle before the falling edge.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        half_nxt  = half;
        shreg_nxt = shreg;
        case (state)
            IDLE: begin
                if (period_zero) begin
                    state_nxt = SETUP;
                    timer_nxt = TMR_LOAD;
                end
            end
            SETUP: begin
                if (timer == '0) begin
                    state_nxt = SHIFT;
                    timer_nxt = TMR_LOAD;
                    half_nxt  = '0;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            SHIFT: begin
                if (timer == '0) begin
                    if (!half[0]) begin
                        shreg_nxt = {shreg[10:0], miso_sync};
                    end
                    if (half == HALF_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        half_nxt  = half + 1'b1;
                        timer_nxt = TMR_LOAD;
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Pins are decoded from the next state so they can be registered.
        cs_n_nxt = !((state_nxt == SETUP) || (state_nxt == SHIFT));
        sclk_nxt = (state_nxt == SHIFT) && !half_nxt[0];
    end

    // State register, registered pins, sample publish and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            half          <= '0;
            shreg         <= '0;
            adc_cs_n      <= 1'b1;
            adc_sclk      <= 1'b0;
            current_b_out <= '0;
            sample_valid  <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            half         <= half_nxt;
            shreg        <= shreg_nxt;
            adc_cs_n     <= cs_n_nxt;
            adc_sclk     <= sclk_nxt;
            sample_valid <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                current_b_out <= shreg_nxt;
            end
            if (period_zero && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
